seeg_seq_ctrl: RTL and testbench

//  Parametrised acquisition sequencer for the sEEG front end: successor to the fixed record/zcheck control in seeg.

---
 rtl/seeg_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_seeg_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seeg_seq_ctrl.sv
// sEEG acquisition sequencer: masked impedance-check sweep or continuous frame recording, one req/ack conversion per slot.
// Optional macro SEEG_ACK_TIMEOUT_EN: a request unacked for ACK_TIMEOUT cycles is dropped and flagged on ack_err.
module seeg_seq_ctrl #(
  parameter int NUM_CH       = 32,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int SLOT_CYCLES  = 39,
  parameter int ZCHECK_DWELL = 390,
  parameter int FRAME_W      = 32,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               record_start,
  input  logic               record_stop,
  input  logic               zcheck_start,
  input  logic [NUM_CH-1:0]  ch_enable,
  input  logic               conv_ack,
  output logic               conv_req,
  output logic [CH_W-1:0]    conv_ch,
  output logic               conv_zmode,
  output logic               record_active,
  output logic               zcheck_active,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               zcheck_done,
  output logic               overrun,
  output logic               ack_err
);

  localparam int MAXC = (ZCHECK_DWELL > SLOT_CYCLES) ? ZCHECK_DWELL : SLOT_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAXC);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ZCHECK_DWELL - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_END   = CNT_W'(SLOT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ZDWELL, S_ZREQ, S_RREQ, S_RWAIT} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               stop_q, stop_d;
  logic               ovr_q, ovr_d;
  logic               fstart_q, fstart_d;
  logic               zdone_q, zdone_d;

  logic [NUM_CH-1:0]  hi_mask;
  logic [CH_W-1:0]    first_ch, next_ch;
  logic               is_last, req_st, hs_done, timeout, stop_now;
  logic               start_ok, zstart_go, rstart_go;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = CH_W'(i);
    end
  endfunction

  // Enabled channels strictly above the current one; empty means the current channel ends the scan.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hi_mask[i] = mask_q[i] && (CH_W'(i) > ch_q);
    end
  end

  assign first_ch  = lowest_ch(mask_q);
  assign next_ch   = lowest_ch(hi_mask);
  assign is_last   = (hi_mask == '0);
  assign req_st    = (state_q == S_ZREQ) || (state_q == S_RREQ);
  assign hs_done   = req_st && (conv_ack || timeout);
  assign stop_now  = record_stop || stop_q;
  assign start_ok  = (state_q == S_IDLE) && (ch_enable != '0);
  assign zstart_go = start_ok && zcheck_start;
  assign rstart_go = start_ok && record_start && !zcheck_start;

`ifdef SEEG_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] wait_q, wait_d;
  logic            ack_err_q, ack_err_d;

  assign timeout = req_st && !conv_ack && (wait_q == TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    wait_d    = (req_st && !hs_done) ? wait_q + TO_W'(1) : '0;
    ack_err_d = ack_err_q;
    if (zstart_go || rstart_go) ack_err_d = 1'b0;
    if (timeout) ack_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q    <= '0;
      ack_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign ack_err = ack_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (ACK_TIMEOUT == 0);
  assign timeout    = 1'b0;
  assign ack_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // cnt_q doubles as dwell counter and slot timer; it saturates so a late ack cannot wrap it.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    frame_d  = frame_q;
    ovr_d    = ovr_q;
    fstart_d = 1'b0;
    zdone_d  = 1'b0;
    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (zstart_go) begin
          state_d = S_ZDWELL;
          mask_d  = ch_enable;
          ch_d    = lowest_ch(ch_enable);
          cnt_d   = '0;
        end else if (rstart_go) begin
          state_d  = S_RREQ;
          mask_d   = ch_enable;
          ch_d     = lowest_ch(ch_enable);
          cnt_d    = '0;
          fstart_d = 1'b1;
          frame_d  = '0;
          ovr_d    = 1'b0;
        end
      end
      S_ZDWELL: begin
        if (record_stop)              state_d = S_IDLE;
        else if (cnt_q == DWELL_LAST) state_d = S_ZREQ;
      end
      S_ZREQ: begin
        if (record_stop) stop_d = 1'b1;
        if (hs_done) begin
          if (is_last) begin
            state_d = S_IDLE;
            zdone_d = 1'b1;
          end else if (stop_now) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ZDWELL;
            ch_d    = next_ch;
            cnt_d   = '0;
          end
        end
      end
      S_RREQ: begin
        if (record_stop) stop_d = 1'b1;
        if (hs_done) begin
          if (conv_ack && (cnt_q >= SLOT_END)) ovr_d = 1'b1;
          if (is_last) frame_d = frame_q + FRAME_W'(1);
          if (stop_now) begin
            state_d = S_IDLE;
          end else begin
            ch_d = is_last ? first_ch : next_ch;
            if (cnt_q >= SLOT_LAST) begin
              state_d  = S_RREQ;
              cnt_d    = '0;
              fstart_d = is_last;
            end else begin
              state_d = S_RWAIT;
            end
          end
        end
      end
      S_RWAIT: begin
        if (record_stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == SLOT_LAST) begin
          state_d  = S_RREQ;
          cnt_d    = '0;
          fstart_d = (ch_q == first_ch);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_q     <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      frame_q  <= '0;
      stop_q   <= 1'b0;
      ovr_q    <= 1'b0;
      fstart_q <= 1'b0;
      zdone_q  <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      stop_q   <= stop_d;
      ovr_q    <= ovr_d;
      fstart_q <= fstart_d;
      zdone_q  <= zdone_d;
    end
  end

  always_comb begin
    conv_req      = req_st;
    zcheck_active = (state_q == S_ZDWELL) || (state_q == S_ZREQ);
    record_active = (state_q == S_RREQ) || (state_q == S_RWAIT);
    conv_zmode    = zcheck_active;
    conv_ch       = (state_q != S_IDLE) ? ch_q : '0;
    frame_start   = fstart_q;
    frame_count   = frame_q;
    zcheck_done   = zdone_q;
    overrun       = ovr_q;
  end

endmodule

// File: tb/tb_seeg_seq_ctrl.sv
// Directed bench for seeg_seq_ctrl: an event-level model predicts every request issue cycle, channel and strobe.
module tb_seeg_seq_ctrl;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SLOT   = 8;
  localparam int DWELL  = 16;
  localparam int FW     = 8;
  localparam int ATO    = 20;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              record_start = 1'b0, record_stop = 1'b0, zcheck_start = 1'b0, conv_ack = 1'b0;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic              conv_req, conv_zmode, record_active, zcheck_active, frame_start;
  logic              zcheck_done, overrun, ack_err;
  logic [CH_W-1:0]   conv_ch;
  logic [FW-1:0]     frame_count;

  seeg_seq_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SLOT_CYCLES(SLOT), .ZCHECK_DWELL(DWELL),
                  .FRAME_W(FW), .ACK_TIMEOUT(ATO)) dut (
    .clk(clk), .rstn(rstn), .record_start(record_start), .record_stop(record_stop),
    .zcheck_start(zcheck_start), .ch_enable(ch_enable), .conv_ack(conv_ack),
    .conv_req(conv_req), .conv_ch(conv_ch), .conv_zmode(conv_zmode),
    .record_active(record_active), .zcheck_active(zcheck_active), .frame_start(frame_start),
    .frame_count(frame_count), .zcheck_done(zcheck_done), .overrun(overrun), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ch; bit zm; bit fs; } req_t;
  req_t expq[$];
  req_t e_cur;

  int cyc = 0, n_chk = 0, n_pass = 0;
  int ack_dly = 2, ack_at = -1, exp_zdone = -1, age = 0;
  int last_issue = -1, prev_issue = -1, prev_ch = 0;
  bit check_en = 1'b0, ack_en = 1'b1, prev_req = 1'b0, prev_ack = 1'b0, issue;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Cycle counter and ack responder: ack is high for exactly one cycle, ack_dly cycles after a request issues.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 conv_ack = ack_en && (cyc == ack_at);
  end

  // A new request is conv_req high where the previous cycle did not hold an unfinished request.
  always @(negedge clk) begin
    issue = conv_req && (!prev_req || prev_ack);
`ifdef SEEG_ACK_TIMEOUT_EN
    if (conv_req && prev_req && !prev_ack && age == ATO - 1) issue = 1'b1;
`endif
    if (issue) begin
      prev_issue = last_issue;
      last_issue = cyc;
      if (ack_en) ack_at = cyc + ack_dly;
    end
    if (check_en) begin
      if (issue) begin
        if (expq.size() == 0) chk("unexpected_req", conv_ch, -1);
        else begin
          e_cur = expq.pop_front();
          chk("req_cycle", cyc, e_cur.cyc);
          chk("req_ch", conv_ch, e_cur.ch);
          chk("req_zmode", conv_zmode, e_cur.zm);
          chk("frame_start", frame_start, e_cur.fs);
        end
      end else if (frame_start) chk("stray_frame_start", frame_start, 0);
      if (conv_req && prev_req && !prev_ack && !issue && conv_ch != prev_ch)
        chk("ch_hold", conv_ch, prev_ch);
      if (zcheck_done || cyc == exp_zdone) chk("zcheck_done", zcheck_done, cyc == exp_zdone);
    end
    age = issue ? 0 : (conv_req ? age + 1 : 0);
    prev_req = conv_req;
    prev_ack = conv_ack;
    prev_ch  = conv_ch;
  end

  task automatic run_record(input logic [3:0] m, input int d, input int nreq, input bit poke);
    int en[$];
    int n0, sp, tl;
    for (int i = 0; i < NUM_CH; i++) if (m[i]) en.push_back(i);
    ack_dly = d;
    sp = (d + 1 > SLOT) ? d + 1 : SLOT;
    n0 = cyc;
    for (int j = 0; j < nreq; j++)
      expq.push_back('{n0 + 1 + j * sp, en[j % en.size()], 1'b0, (j % en.size()) == 0});
    ch_enable = m; record_start = 1'b1;
    tick();
    record_start = 1'b0; ch_enable = m ^ 4'b0110;
    chk("rec_active_on", record_active, 1);
    chk("overrun_cleared", overrun, 0);
    chk("frame_count_cleared", frame_count, 0);
    chk("ack_err_cleared", ack_err, 0);
    if (poke) begin
      tick(3);
      zcheck_start = 1'b1; record_start = 1'b1;
      tick();
      zcheck_start = 1'b0; record_start = 1'b0;
    end
    tl = n0 + 1 + (nreq - 1) * sp;
    wait_cyc(tl + 1);
    record_stop = 1'b1;
    tick();
    record_stop = 1'b0;
    wait_cyc(tl + d);
    chk("rec_active_until_ack", record_active, 1);
    tick();
    chk("rec_idle_after_stop", record_active, 0);
    chk("req_low_after_stop", conv_req, 0);
    chk("frame_count", frame_count, (nreq / en.size()) % (1 << FW));
    chk("overrun", overrun, d >= SLOT);
    tick(SLOT + 2);
    chk("pending_reqs", expq.size(), 0);
  endtask

  task automatic run_zcheck(input logic [3:0] m, input int d, input bit both);
    int en[$];
    int n0, t, tl;
    for (int i = 0; i < NUM_CH; i++) if (m[i]) en.push_back(i);
    ack_dly = d;
    n0 = cyc;
    t = n0 + 1 + DWELL;
    tl = t;
    foreach (en[k]) begin
      expq.push_back('{t, en[k], 1'b1, 1'b0});
      tl = t;
      t = t + d + 1 + DWELL;
    end
    exp_zdone = tl + d + 1;
    ch_enable = m; zcheck_start = 1'b1; record_start = both;
    tick();
    zcheck_start = 1'b0; record_start = 1'b0;
    chk("z_active_on", zcheck_active, 1);
    chk("z_not_recording", record_active, 0);
    chk("z_zmode", conv_zmode, 1);
    chk("z_first_ch", conv_ch, en[0]);
    chk("z_dwell_no_req", conv_req, 0);
    wait_cyc(exp_zdone);
    chk("z_idle_at_done", zcheck_active, 0);
    tick(3);
    chk("pending_reqs", expq.size(), 0);
    exp_zdone = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    #1 rstn = 1'b0;
    tick(3);
    chk("rst_conv_req", conv_req, 0);
    chk("rst_conv_ch", conv_ch, 0);
    chk("rst_conv_zmode", conv_zmode, 0);
    chk("rst_record_active", record_active, 0);
    chk("rst_zcheck_active", zcheck_active, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_zcheck_done", zcheck_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ack_err", ack_err, 0);
    rstn = 1'b1;
    tick(2);
    check_en = 1'b1;

    // Sweep over 0,1,3: issues at +17, +36, +55; done at +58.
    n0 = cyc;
    run_zcheck(4'b1011, 2, 1'b0);
    chk("z_spacing_literal", last_issue - prev_issue, 19);
    chk("z_last_issue_literal", last_issue - n0, 55);

    run_zcheck(4'b0101, 2, 1'b1);

    ch_enable = 4'b0110; zcheck_start = 1'b1;
    tick();
    zcheck_start = 1'b0;
    tick(4);
    chk("dwell_active", zcheck_active, 1);
    record_stop = 1'b1;
    tick();
    record_stop = 1'b0;
    chk("dwell_abort_idle", zcheck_active, 0);
    chk("dwell_abort_zmode", conv_zmode, 0);
    tick(DWELL + 4);

    run_record(4'hF, 2, 13, 1'b1);
    chk("rec_frames_literal", frame_count, 3);
    chk("rec_spacing_literal", last_issue - prev_issue, 8);

    run_record(4'hF, 10, 9, 1'b0);
    chk("ovr_literal", overrun, 1);
    chk("ovr_spacing_literal", last_issue - prev_issue, 11);

    run_record(4'b1010, 2, 5, 1'b0);

    ch_enable = 4'b0000; record_start = 1'b1;
    tick();
    record_start = 1'b0;
    chk("zero_mask_record", record_active, 0);
    zcheck_start = 1'b1;
    tick();
    zcheck_start = 1'b0;
    chk("zero_mask_zcheck", zcheck_active, 0);
    tick(DWELL + 4);

    check_en = 1'b0; ack_dly = 2;
    ch_enable = 4'hF; record_start = 1'b1;
    tick();
    record_start = 1'b0;
    tick(12);
    chk("pre_reset_active", record_active, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_req", conv_req, 0);
    chk("async_rst_active", record_active, 0);
    chk("async_rst_frame_start", frame_start, 0);
    chk("async_rst_ch", conv_ch, 0);
    tick(2);
    rstn = 1'b1;
    tick();
    expq.delete(); ack_at = -1; exp_zdone = -1;
    check_en = 1'b1;
    run_record(4'hF, 2, 5, 1'b0);

`ifdef SEEG_ACK_TIMEOUT_EN
    ack_en = 1'b0;
    n0 = cyc;
    expq.push_back('{n0 + 1, 0, 1'b0, 1'b1});
    expq.push_back('{n0 + 1 + ATO, 1, 1'b0, 1'b0});
    ch_enable = 4'hF; record_start = 1'b1;
    tick();
    record_start = 1'b0;
    wait_cyc(n0 + ATO);
    chk("to_no_err_yet", ack_err, 0);
    tick();
    chk("to_ack_err", ack_err, 1);
    chk("to_no_overrun", overrun, 0);
    record_stop = 1'b1;
    tick();
    record_stop = 1'b0;
    wait_cyc(n0 + 2 * ATO + 1);
    chk("to_stop_idle", record_active, 0);
    chk("pending_reqs", expq.size(), 0);
    ack_en = 1'b1;
    tick(2);
`endif

    run_record(4'b0001, 2, 257, 1'b0);
    chk("frame_wrap_literal", frame_count, 1);
`ifndef SEEG_ACK_TIMEOUT_EN
    chk("ack_err_tied_low", ack_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
